max7219_matrix_display: RTL and testbench
=========================================

# max7219_matrix_display

Serial driver for a daisy-chain of SIZE MAX7219 8×8 LED-matrix controllers. The block sits at the output end of the scrolling-text display path. It takes a flat 64·SIZE-bit pixel image from the column shifters and the character ROM. It runs directly on the SPI-rate clock produced by the PLL, and that same clock is also wired to the devices' CLK pin. After reset it programs every device once, then refreshes rows 1–8 continuously.

## Interface
- SIZE, 4: number of chained MAX7219 devices (≥1).
- INTENSITY, 4'h3: value written to the intensity register (0x0A).
- clk  in  1: SPI clock, also routed to device CLK.
- reset_n  in  1: reset, asynchronous, active-low; clock clk.
- pixels  in  64·SIZE: image. Device k uses pixels[64k +: 64]; row r (r=0..7) of device k is pixels[64k+8r +: 8]. Device 0 is the one nearest mosi; device SIZE-1 is the farthest.
- mosi  out  1: serial data to DIN of device 0.
- cs  out  1: LOAD/CS, active-low; rising edge latches.

## Operation
- Frame: one 16-bit word per device, {4'h0, addr[3:0], data[7:0]}, sent MSB first.
  - The farthest device's word (k=SIZE-1) goes first; device 0's word goes last.
  - Total 16·SIZE bits per frame.
- Init sequence: 5 frames, same word to all devices, in this order:
  - 0x0F00: display test off.
  - 0x0B07: scan limit 8.
  - 0x0900: no decode.
  - 0x0A0{INTENSITY}.
  - 0x0C01: normal operation.
- Refresh: frames for digit registers addr=1..8, then wrap to 1, forever.
  - Frame for addr=r+1 carries row r of each device.
  - Init is never repeated except after reset.
- Pixel snapshot: pixels are captured into an internal register at the start of each refresh frame, on the edge where cs falls. Changes to pixels mid-frame do not affect that frame.
- States: INIT(step 0..4) → ROW(1..8, wrap). Each state has sub-phases SHIFT(bit count 16·SIZE-1 down to 0) → LATCH.

## Timing
- mosi and cs change only on the falling edge of clk, so data is stable at the device's rising-edge sample.
- Reset values: cs=1, mosi=0, state=INIT step 0, bit counter cleared.
- Reset is asynchronous. Assertion mid-frame forces cs=1 immediately; a partial word may latch, which is acceptable. Init reruns in full after release.
- First falling edge after reset_n rises: cs=0, mosi = bit 15 of the first word.
- Each bit is held for exactly one clk period. Bit j of the frame is presented on falling edge j (j=0..16·SIZE-1).
- Falling edge 16·SIZE: cs=1, mosi=0 (LATCH, one cycle).
- Next falling edge: cs=0 and the next frame's first bit. There are no gaps beyond this one cycle.
- Frame period: 16·SIZE+1 clk cycles. Full refresh: 8·(16·SIZE+1) cycles, which is 520 for SIZE=4.
- Bit counter width is $clog2(16·SIZE). Row index is 3-bit and wraps 7→0 (addr 8→1).

## Structure
- Package max7219_pkg holds:
  - Register address constants: NOOP 0x0, DIGIT0 0x1, DECODE 0x9, INTENSITY 0xA, SCANLIMIT 0xB, SHUTDOWN 0xC, DISPTEST 0xF.
  - The 16-bit word composition function.
  - The init table (5 words).
- One sub-module, max7219_frame_tx:
  - Loads a 16·SIZE-bit frame and shifts it out MSB-first on negedge clk.
  - Generates cs and signals done.
- The top FSM in this block handles sequencing and the pixel snapshot.

## Test plan
- SIZE=1, release reset: the first 5 frames decode to 0x0F00, 0x0B07, 0x0900, 0x0A03, 0x0C01. Each is 16 bits with cs low, followed by one cycle of cs high.
- SIZE=4, pixels={64'h0, 64'h0, 64'h0, 64'h00000000000000AA}: the addr=1 frame is 0x0100, 0x0100, 0x0100, 0x01AA, in shift order.
- SIZE=4: cs is low for exactly 64 cycles, high for 1, and the frame period is 65. Digit addr sequence 1..8 then 1 again, 520 cycles per refresh.
- Change pixels mid-frame: the current frame is unchanged and the next frame reflects the new value.
- Assert reset_n mid-refresh frame: cs=1 and mosi=0 immediately. After release, the sequence restarts at 0x0F00.
- Sample mosi on rising clk edges: it matches the expected bit stream, with no transition coincident with a rising edge.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared constants and word helpers for the MAX7219 chain driver.
// Holds register addresses, 16-bit word packing and the power-up register table.
package max7219_pkg;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_DISPTEST  = 4'hF;

  localparam int INIT_STEPS = 5;

  typedef enum logic {
    ST_INIT,
    ST_ROW
  } state_t;

  function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

  function automatic logic [15:0] init_word(input logic [2:0] step, input logic [3:0] intensity);
    case (step)
      3'd0:    return make_word(ADDR_DISPTEST, 8'h00);
      3'd1:    return make_word(ADDR_SCANLIMIT, 8'h07);
      3'd2:    return make_word(ADDR_DECODE, 8'h00);
      3'd3:    return make_word(ADDR_INTENSITY, {4'h0, intensity});
      3'd4:    return make_word(ADDR_SHUTDOWN, 8'h01);
      default: return make_word(ADDR_NOOP, 8'h00);
    endcase
  endfunction

endpackage

// File: rtl/max7219_frame_tx.sv
// Presents one frame MSB-first on falling clk edges with cs low, then a one-cycle cs-high latch.
// start marks the edge where cs falls; done marks the edge where cs rises.
module max7219_frame_tx #(
  parameter int N_BITS = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_BITS-1:0] frame,
  output logic              start,
  output logic              done,
  output logic              mosi,
  output logic              cs
);

  localparam int CNT_W = $clog2(N_BITS);

  logic             busy;
  logic [CNT_W-1:0] cnt;

  assign start = !busy;
  assign done  = busy && (cnt == '0);

  // cnt is the frame bit index currently on mosi; it walks N_BITS-1 down to 0.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      cs   <= 1'b1;
      mosi <= 1'b0;
    end else if (!busy) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(N_BITS - 1);
      cs   <= 1'b0;
      mosi <= frame[N_BITS-1];
    end else if (cnt != '0) begin
      cnt  <= cnt - 1'b1;
      mosi <= frame[cnt - 1'b1];
    end else begin
      busy <= 1'b0;
      cs   <= 1'b1;
      mosi <= 1'b0;
    end
  end

endmodule

// File: rtl/max7219_matrix_display.sv
// Sequencer for a chain of SIZE MAX7219 matrices: one-shot init table, then endless row refresh.
// Everything runs on the falling edge so outputs are settled for the devices' rising-edge sample.
module max7219_matrix_display
  import max7219_pkg::*;
#(
  parameter int          SIZE      = 4,
  parameter logic [3:0]  INTENSITY = 4'h3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [64*SIZE-1:0]  pixels,
  output logic                mosi,
  output logic                cs
);

  localparam int N_BITS = 16 * SIZE;

  state_t              state;
  logic [2:0]          step;
  logic [2:0]          row;
  logic [64*SIZE-1:0]  snap;
  logic [N_BITS-1:0]   frame;
  logic                tx_start;
  logic                tx_done;

  // Device k's word lands in frame[16k +: 16], so the farthest device is shifted first.
  always_comb begin
    frame = '0;
    for (int k = 0; k < SIZE; k++) begin
      if (state == ST_INIT)
        frame[16*k +: 16] = init_word(step, INTENSITY);
      else
        frame[16*k +: 16] = make_word(ADDR_DIGIT0 + {1'b0, row}, snap[64*k + 8*row +: 8]);
    end
  end

  // The snapshot is taken on the cs-falling edge; the bit sent on that same edge is the
  // zero top nibble of a word, so the stale snapshot never reaches mosi.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      step  <= 3'd0;
      row   <= 3'd0;
      snap  <= '0;
    end else begin
      if (tx_start && state == ST_ROW)
        snap <= pixels;
      if (tx_done) begin
        case (state)
          ST_INIT: begin
            if (step == 3'(INIT_STEPS - 1)) begin
              state <= ST_ROW;
              row   <= 3'd0;
            end else begin
              step <= step + 3'd1;
            end
          end
          ST_ROW:  row <= row + 3'd1;
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  max7219_frame_tx #(.N_BITS(N_BITS)) u_frame_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .frame   (frame),
    .start   (tx_start),
    .done    (tx_done),
    .mosi    (mosi),
    .cs      (cs)
  );

endmodule

// File: tb/tb_max7219_matrix_display.sv
// Bench for the MAX7219 chain driver: decodes the serial stream frame by frame
// and compares it with words built from the register map and a pixel snapshot.
module tb_max7219_matrix_display;

  localparam int SIZE = 4;
  localparam int N    = 16 * SIZE;
  localparam int PW   = 64 * SIZE;
  localparam logic [15:0] INIT_TBL [5] = '{16'h0F00, 16'h0B07, 16'h0900, 16'h0A03, 16'h0C01};
  localparam logic [PW-1:0] PIX_AA = PW'(64'h00000000000000AA);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [PW-1:0] pixels;
  logic          mosi;
  logic          cs;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_glitch = 0;
  time         t_last_start;
  time         t_row1;
  logic [63:0] last_frame;

  always #5 clk = ~clk;

  max7219_matrix_display #(.SIZE(SIZE), .INTENSITY(4'h3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pixels  (pixels),
    .mosi    (mosi),
    .cs      (cs)
  );

  // Outside reset, outputs may only move on falling edges (multiples of 10).
  always @(mosi or cs) begin
    if (reset_n === 1'b1 && ($time % 10) != 0) n_glitch++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_pix();
    logic [PW-1:0] p;
    for (int i = 0; i < PW / 32; i++) p[32*i +: 32] = $urandom;
    return p;
  endfunction

  // Frame f after reset: 5 init words broadcast, then rows 1..8 repeating.
  function automatic logic [63:0] exp_frame(input int f, input logic [PW-1:0] pix);
    logic [63:0] r;
    logic [15:0] w;
    int          rw;
    r = '0;
    for (int k = SIZE - 1; k >= 0; k--) begin
      if (f < 5) begin
        w = INIT_TBL[f];
      end else begin
        rw = (f - 5) % 8;
        w  = {4'h0, 4'(rw + 1), pix[64*k + 8*rw +: 8]};
      end
      r = (r << 16) | 64'(w);
    end
    return r;
  endfunction

  // mode 0: pixels untouched, 1: random change at a random bit, 2: switch to PIX_AA.
  task automatic run_frame(input int f, input int mode);
    logic [63:0]   got;
    logic [63:0]   exp;
    logic [PW-1:0] pix;
    int            lows;
    int            pos;
    pos = $urandom_range(0, N);
    @(posedge clk);
    t_last_start = $time;
    pix  = pixels;
    exp  = exp_frame(f, pix);
    got  = '0;
    lows = 0;
    for (int j = 0; j < N; j++) begin
      if (j > 0) @(posedge clk);
      if (cs === 1'b0) lows++;
      got = {got[62:0], mosi};
      if (mode != 0 && j == pos) #1 pixels = (mode == 2) ? PIX_AA : rand_pix();
    end
    @(posedge clk);
    chk($sformatf("latch_cs_f%0d", f), 64'(cs), 64'd1);
    chk($sformatf("latch_mosi_f%0d", f), 64'(mosi), 64'd0);
    if (mode != 0 && pos == N) #1 pixels = (mode == 2) ? PIX_AA : rand_pix();
    chk($sformatf("frame_f%0d", f), got, exp);
    chk($sformatf("cs_low_bits_f%0d", f), 64'(lows), 64'(N));
    last_frame = got;
  endtask

  initial begin
    pixels  = rand_pix();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    chk("rst_cs", 64'(cs), 64'd1);
    chk("rst_mosi", 64'(mosi), 64'd0);
    #1 reset_n = 1'b1;

    for (int f = 0; f < 4; f++) run_frame(f, 1);
    run_frame(4, 2);
    run_frame(5, 1);
    chk("aa_row1_frame", last_frame, 64'h0100_0100_0100_01AA);
    t_row1 = t_last_start;
    for (int f = 6; f < 14; f++) run_frame(f, 1);
    chk("refresh_cycles", 64'((t_last_start - t_row1) / 10), 64'd520);

    // Abort the next frame part-way through with an asynchronous reset.
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_cs", 64'(cs), 64'd1);
    chk("midrst_mosi", 64'(mosi), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int f = 0; f < 7; f++) run_frame(f, 1);

    chk("edge_glitches", 64'(n_glitch), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
